// File: rtl/perc_learn_pkg.sv
// Shared definitions for the perc_learn perceptron block.
//   state_e    : controller states (IDLE, ACC, DECIDE, UPDATE)
//   acc_width  : accumulator / threshold width for n inputs of ww-bit weights
//   addr_width : parameter-write address width (n weights + 1 threshold)
package perc_learn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    DECIDE = 2'd2,
    UPDATE = 2'd3
  } state_e;

  // A sum of n signed ww-bit values spans at most n * 2^(ww-1) in magnitude.
  // That fits in ww + clog2(n) signed bits. The extra bit is headroom, so the
  // accumulator can never overflow whatever weights are loaded.
  function automatic int acc_width(input int n, input int ww);
    return ww + $clog2(n) + 1;
  endfunction

  // Addresses 0..n-1 select weights and address n selects the threshold.
  function automatic int addr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/perc_sat_step.sv
// Saturating +/-1 step for one perceptron weight (purely combinational).
//   w_cur : current signed weight
//   en    : apply the step (the feature bit for this weight was 1)
//   up    : 1 = step towards +max, 0 = step towards -min
//   w_nxt : stepped weight, clamped to [-2^(WW-1), 2^(WW-1)-1]
module perc_sat_step #(
  parameter int WW = 8
) (
  input  logic signed [WW-1:0] w_cur,
  input  logic                 en,
  input  logic                 up,
  output logic signed [WW-1:0] w_nxt
);

  localparam logic signed [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [WW-1:0] W_MIN = {1'b1, {(WW-1){1'b0}}};

  // NOTE: every output of a combinational block gets a default first. If a
  // path leaves an output unassigned, the tool infers a latch.
  always_comb begin
    w_nxt = w_cur;
    if (en) begin
      if (up) begin
        if (w_cur != W_MAX) w_nxt = w_cur + WW'(1);
      end else begin
        if (w_cur != W_MIN) w_nxt = w_cur - WW'(1);
      end
    end
  end

endmodule

// File: rtl/perc_learn.sv
// Single-neuron perceptron with on-line learning.
// A sample is accepted in IDLE. The controller then spends N cycles summing
// the weights of the set feature bits, registers the thresholded decision
// with a one-cycle out_valid pulse, and optionally applies one saturating
// +/-1 learning step to every active weight.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : sample handshake
//   data_in              : N-bit binary feature vector (bit i = x[i])
//   in_train, in_target  : learning request and desired output
//   data_out, out_valid  : decision (held) and new-decision pulse
//   wr_en/wr_addr/wr_data: weight (addr < N) or threshold (addr == N) write,
//                          honoured only in IDLE
//   err_cnt              : saturating count of trained mispredictions
module perc_learn
  import perc_learn_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int WW     = 8,
  parameter  int THRESH = 10,
  localparam int AW     = acc_width(N, WW),
  localparam int ADW    = addr_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   data_in,
  input  logic           in_train,
  input  logic           in_target,
  output logic           data_out,
  output logic           out_valid,
  input  logic           wr_en,
  input  logic [ADW-1:0] wr_addr,
  input  logic [AW-1:0]  wr_data,
  output logic [15:0]    err_cnt
);

  localparam int IW = $clog2(N);

  state_e               state_q, state_d;
  logic [N-1:0]         x_q, x_d;
  logic                 train_q, train_d;
  logic                 target_q, target_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [WW-1:0] w_q [N];
  logic signed [WW-1:0] w_d [N];
  logic signed [WW-1:0] w_step [N];
  logic signed [AW-1:0] thr_q, thr_d;
  logic                 dout_q, dout_d;
  logic                 ovalid_q, ovalid_d;
  logic [15:0]          err_q, err_d;

  logic accept;
  logic decision;

  // A pending parameter write takes priority over an offered sample.
  assign in_ready = (state_q == IDLE) && !wr_en;
  assign accept   = in_valid && in_ready;
  assign decision = (acc_q >= thr_q);  // both operands signed

  for (genvar g = 0; g < N; g++) begin : g_step
    perc_sat_step #(.WW(WW)) u_step (
      .w_cur (w_q[g]),
      .en    (x_q[g]),
      .up    (target_q),
      .w_nxt (w_step[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    train_d  = train_q;
    target_d = target_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    w_d      = w_q;
    thr_d    = thr_q;
    dout_d   = dout_q;
    ovalid_d = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          for (int i = 0; i < N; i++) begin
            if (wr_addr == ADW'(i)) w_d[i] = wr_data[WW-1:0];
          end
          if (wr_addr == ADW'(N)) thr_d = wr_data;
        end else if (accept) begin
          x_d      = data_in;
          train_d  = in_train;
          target_d = in_target;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACC;
        end
      end

      ACC: begin
        // One weight per cycle, chosen by idx_q and sign-extended to AW.
        for (int i = 0; i < N; i++) begin
          if (idx_q == IW'(i) && x_q[i]) begin
            acc_d = acc_q + {{(AW-WW){w_q[i][WW-1]}}, w_q[i]};
          end
        end
        if (idx_q == IW'(N - 1)) begin
          idx_d   = '0;
          state_d = DECIDE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      DECIDE: begin
        dout_d   = decision;
        ovalid_d = 1'b1;
        state_d  = (train_q && (decision != target_q)) ? UPDATE : IDLE;
      end

      UPDATE: begin
        w_d = w_step;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples its old value at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      train_q  <= 1'b0;
      target_q <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      // NOTE: the weight array is a handful of flops rather than a RAM. That
      // makes it legal and cheap to clear on reset, and learning must restart
      // from zero weights.
      for (int i = 0; i < N; i++) w_q[i] <= '0;
      thr_q    <= AW'(THRESH);
      dout_q   <= 1'b0;
      ovalid_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      train_q  <= train_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      thr_q    <= thr_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = ovalid_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_perc_learn.sv
// Directed self-checking bench for perc_learn (N=4, WW=8, THRESH=10).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_perc_learn;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  data_in;
  logic        in_train;
  logic        in_target;
  logic        data_out;
  logic        out_valid;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [10:0] wr_data;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic dec;
  int   lat;
  int   pulses;

  always #5 clk = ~clk;

  perc_learn dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .in_train  (in_train),
    .in_target (in_target),
    .data_out  (data_out),
    .out_valid (out_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_param(input logic [2:0] a, input logic [10:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called right after the accept edge E0; k counts edges after E0.
  task automatic wait_result(output logic d, output int l, output int p);
    d = 1'b0; l = -1; p = 0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (out_valid) begin
        p++;
        if (l < 0) begin l = k; d = data_out; end
      end
      if (l >= 0 && in_ready) break;
    end
  endtask

  task automatic run_sample(input logic [3:0] x, input logic trn, input logic tgt,
                            output logic d, output int l, output int p);
    @(negedge clk);
    data_in = x; in_train = trn; in_target = tgt; in_valid = 1'b1;
    @(posedge clk);
    wait_result(d, l, p);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 24; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in = '0; in_train = 1'b0; in_target = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_thr", {21'd0, dut.thr_q}, 32'd10);
    for (int i = 0; i < 4; i++) check($sformatf("rst_w%0d", i), {24'd0, dut.w_q[i]}, 32'd0);

    // w = 1,2,4,8, thr = 10
    wr_param(3'd0, 11'd1);
    wr_param(3'd1, 11'd2);
    wr_param(3'd2, 11'd4);
    wr_param(3'd3, 11'd8);
    wr_param(3'd4, 11'd10);
    run_sample(4'b1011, 1'b0, 1'b0, dec, lat, pulses);  // 1+2+8 = 11
    check("s1011_latency", 32'(lat), 32'd5);
    check("s1011_pulses", 32'(pulses), 32'd1);
    check("s1011_dec", 32'(dec), 32'd1);
    check("s1011_hold", 32'(data_out), 32'd1);

    run_sample(4'b0101, 1'b0, 1'b0, dec, lat, pulses);  // 1+4 = 5
    check("s0101_dec", 32'(dec), 32'd0);
    check("s0101_err", 32'(err_cnt), 32'd0);
    run_sample(4'b0101, 1'b1, 1'b0, dec, lat, pulses);  // trained, already correct
    check("s0101t_dec", 32'(dec), 32'd0);
    check("s0101t_err", 32'(err_cnt), 32'd0);
    check("s0101t_w0", {24'd0, dut.w_q[0]}, 32'd1);

    // Out-of-range address is ignored
    wr_param(3'd5, 11'd99);
    check("oob_thr", {21'd0, dut.thr_q}, 32'd10);
    check("oob_w3", {24'd0, dut.w_q[3]}, 32'd8);

    // Learning from zero weights, thr = 1
    do_reset();
    wr_param(3'd4, 11'd1);
    run_sample(4'b0011, 1'b1, 1'b1, dec, lat, pulses);  // sum 0 < 1
    check("learn1_dec", 32'(dec), 32'd0);
    check("learn1_err", 32'(err_cnt), 32'd1);
    check("learn1_w0", {24'd0, dut.w_q[0]}, 32'd1);
    check("learn1_w1", {24'd0, dut.w_q[1]}, 32'd1);
    check("learn1_w2", {24'd0, dut.w_q[2]}, 32'd0);
    run_sample(4'b0011, 1'b1, 1'b1, dec, lat, pulses);  // sum 2 >= 1
    check("learn2_dec", 32'(dec), 32'd1);
    check("learn2_err", 32'(err_cnt), 32'd1);
    run_sample(4'b0001, 1'b1, 1'b0, dec, lat, pulses);  // sum 1 >= 1, target 0
    check("learn3_dec", 32'(dec), 32'd1);
    check("learn3_w0", {24'd0, dut.w_q[0]}, 32'd0);
    check("learn3_w1", {24'd0, dut.w_q[1]}, 32'd1);
    check("learn3_err", 32'(err_cnt), 32'd2);

    // Saturation at +127 and -128
    do_reset();
    wr_param(3'd0, 11'd127);
    wr_param(3'd4, 11'd127);
    run_sample(4'b0001, 1'b1, 1'b1, dec, lat, pulses);  // 127 >= 127
    check("satp1_dec", 32'(dec), 32'd1);
    check("satp1_err", 32'(err_cnt), 32'd0);
    wr_param(3'd4, 11'd200);
    run_sample(4'b0001, 1'b1, 1'b1, dec, lat, pulses);  // 127 < 200
    check("satp2_dec", 32'(dec), 32'd0);
    check("satp2_w0", {24'd0, dut.w_q[0]}, 32'd127);
    check("satp2_err", 32'(err_cnt), 32'd1);
    wr_param(3'd1, 11'h780);                            // -128
    wr_param(3'd4, 11'h738);                            // -200
    run_sample(4'b0010, 1'b1, 1'b0, dec, lat, pulses);  // -128 >= -200, target 0
    check("satn_dec", 32'(dec), 32'd1);
    check("satn_w1", {24'd0, dut.w_q[1]}, 32'h80);
    check("satn_err", 32'(err_cnt), 32'd2);

    // Wide sums: 4 * 127 = 508
    wr_param(3'd1, 11'd127);
    wr_param(3'd2, 11'd127);
    wr_param(3'd3, 11'd127);
    wr_param(3'd4, 11'd508);
    run_sample(4'b1111, 1'b0, 1'b0, dec, lat, pulses);
    check("wide_eq_dec", 32'(dec), 32'd1);
    wr_param(3'd4, 11'd509);
    run_sample(4'b1111, 1'b0, 1'b0, dec, lat, pulses);
    check("wide_gt_dec", 32'(dec), 32'd0);
    // 4 * -128 = -512, threshold -511
    for (int i = 0; i < 4; i++) wr_param(3'(i), 11'h780);
    wr_param(3'd4, 11'h601);
    run_sample(4'b1111, 1'b0, 1'b0, dec, lat, pulses);
    check("wide_neg_dec", 32'(dec), 32'd0);

    // Reset in the 2nd ACC cycle
    do_reset();
    wr_param(3'd0, 11'd5);
    wr_param(3'd4, 11'd3);
    @(negedge clk);
    data_in = 4'b0001; in_train = 1'b1; in_target = 1'b0; in_valid = 1'b1;
    @(posedge clk);                 // E0
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;     // 2nd ACC cycle
    @(negedge clk); rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_w0", {24'd0, dut.w_q[0]}, 32'd0);
    check("abort_thr", {21'd0, dut.thr_q}, 32'd10);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);

    // Write during ACC is ignored
    wr_param(3'd0, 11'd3);
    @(negedge clk);
    data_in = 4'b0001; in_train = 1'b0; in_valid = 1'b1;
    @(posedge clk);                 // E0
    @(negedge clk);
    in_valid = 1'b0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 11'd50;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle();
    check("accwr_idle", 32'(in_ready), 32'd1);
    check("accwr_w0", {24'd0, dut.w_q[0]}, 32'd3);
    check("accwr_dec", 32'(data_out), 32'd0);

    // Write and sample in the same IDLE cycle: write wins, sample waits
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 11'd12;
    data_in = 4'b0001; in_train = 1'b0; in_valid = 1'b1;
    #1;
    check("both_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("both_w0", {24'd0, dut.w_q[0]}, 32'd12);
    check("both_still_idle", 32'(in_ready), 32'd1);
    @(posedge clk);                 // accept edge
    wait_result(dec, lat, pulses);
    check("both_latency", 32'(lat), 32'd5);
    check("both_dec", 32'(dec), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
